step_control_engine: RTL and testbench

- Parametrised adaptive step-size controller for the ODE solver.
- Init phase: reads n, tolerance and initial step h from memory.
- Each `start`: compares two solution estimates per component, reduces them to an error norm (sum-abs or max-abs) and accepts or rejects the step.
- On reject: computes h_new = clamp(h*tol/err) via external multiplier/divider handshakes. On a well-below-tolerance accept: optionally grows h. Consecutive rejects are capped.

---
 rtl/step_ctrl_pkg.sv | 34 +++
 rtl/err_norm_accum.sv | 44 ++++
 rtl/step_control_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_step_control_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types for the adaptive step-size controller: FSM states, config
// offsets and norm-mode encodings.
package step_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_CFG_N,
    S_CFG_T,
    S_CFG_H,
    S_CFG_LAST,
    S_DONE_INIT,
    S_ERR_INIT,
    S_ERR_RD_Y,
    S_ERR_RD_Z,
    S_ERR_ACC,
    S_CMP,
    S_MUL,
    S_WAIT_MUL,
    S_DIV,
    S_WAIT_DIV,
    S_CLAMP,
    S_DONE_PROCEED,
    S_DONE_NO_PROCEED,
    S_ERROR
  } state_t;

  localparam int CFG_N_OFS = 0;
  localparam int CFG_T_OFS = 1;
  localparam int CFG_H_OFS = 2;

  localparam logic NORM_SUM = 1'b0;
  localparam logic NORM_MAX = 1'b1;

endpackage

// File: rtl/err_norm_accum.sv
// Error-norm accumulator: |y-z| at DATA_W+1 bits folded into a sum or a max,
// with a combinational fault flag for out-of-range differences or sum overflow.
module err_norm_accum
  import step_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              mode,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] z,
  output logic [DATA_W-1:0] acc,
  output logic              sat
);

  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] mag;
  logic        [DATA_W:0] sum;
  logic                   big_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    diff  = {y[DATA_W-1], y} - {z[DATA_W-1], z};
    mag   = diff[DATA_W] ? -diff : diff;
    big_d = mag[DATA_W] | mag[DATA_W-1];
    sum   = {1'b0, acc} + mag;
    sat   = en & (big_d | ((mode == NORM_SUM) & (sum[DATA_W] | sum[DATA_W-1])));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en && !sat) begin
      if (mode == NORM_MAX) acc <= (mag[DATA_W-1:0] > acc) ? mag[DATA_W-1:0] : acc;
      else                  acc <= sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/step_control_engine.sv
// Adaptive step-size controller: loads n/tol/h, reduces |Y-Z| to an error norm,
// accepts (optionally growing h) or rejects and rescales h = clamp(h*tol/err).
module step_control_engine
  import step_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int CFG_BASE   = 0,
  parameter int Y_BASE     = 16,
  parameter int Z_BASE     = 512,
  parameter int N_W        = 8,
  parameter int MAX_RETRY  = 4,
  parameter int GROW_SHIFT = 3,
  parameter int H_MIN      = 1,
  parameter logic [DATA_W-1:0] H_MAX = {2'b01, {(DATA_W-2){1'b0}}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init,
  input  logic                               start,
  input  logic                               norm_mode,
  input  logic                               grow_en,
  output logic                               mem_rd,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [DATA_W-1:0]                  mem_data,
  output logic                               mul_start,
  output logic [DATA_W-1:0]                  mul_a,
  output logic [DATA_W-1:0]                  mul_b,
  input  logic                               mul_done,
  input  logic [DATA_W-1:0]                  mul_result,
  input  logic                               mul_overflow,
  output logic                               div_start,
  output logic [DATA_W-1:0]                  div_num,
  output logic [DATA_W-1:0]                  div_den,
  input  logic                               div_done,
  input  logic [DATA_W-1:0]                  div_quot,
  input  logic                               div_overflow,
  output logic [DATA_W-1:0]                  step,
  output logic [DATA_W-1:0]                  err_norm,
  output logic                               done,
  output logic                               proceed,
  output logic                               error_failure,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_count
);

  localparam logic [DATA_W-1:0] H_MIN_V = DATA_W'(H_MIN);

  state_t            state;
  logic [N_W-1:0]    n;
  logic [N_W-1:0]    idx;
  logic [N_W-1:0]    idx_nxt;
  logic [N_W-1:0]    n_last;
  logic [DATA_W-1:0] tol;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] quot;
  logic              mode_q;
  logic              grow_q;
  logic [DATA_W-1:0] acc;
  logic              acc_sat;
  logic [DATA_W:0]   h_dbl;
  logic [DATA_W-1:0] h_grown;

  function automatic logic [DATA_W-1:0] clamp_h(input logic [DATA_W-1:0] v);
    if ($signed(v) < $signed(H_MIN_V)) return H_MIN_V;
    if ($signed(v) > $signed(H_MAX))   return H_MAX;
    return v;
  endfunction

  // n = 0 is treated as a single component
  assign n_last  = (n == '0) ? '0 : n - N_W'(1);
  assign idx_nxt = idx + N_W'(1);
  assign h_dbl   = {step, 1'b0};
  assign h_grown = (h_dbl > {1'b0, H_MAX}) ? H_MAX : h_dbl[DATA_W-1:0];

  assign done          = (state == S_DONE_INIT) || (state == S_DONE_PROCEED) ||
                         (state == S_DONE_NO_PROCEED);
  assign proceed       = (state == S_DONE_PROCEED);
  assign error_failure = (state == S_ERROR);
  assign mul_a         = step;
  assign mul_b         = tol;
  assign div_num       = product;
  assign div_den       = acc;

  err_norm_accum #(.DATA_W(DATA_W)) u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_ERR_INIT),
    .en   (state == S_ERR_ACC),
    .mode (mode_q),
    .y    (y_q),
    .z    (mem_data),
    .acc  (acc),
    .sat  (acc_sat)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      step        <= '0;
      err_norm    <= '0;
      retry_count <= '0;
      n           <= '0;
      tol         <= '0;
      idx         <= '0;
      y_q         <= '0;
      product     <= '0;
      quot        <= '0;
      mode_q      <= 1'b0;
      grow_q      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE_INIT, S_DONE_PROCEED, S_DONE_NO_PROCEED, S_ERROR: begin
          if (init) begin
            state       <= S_CFG_N;
            retry_count <= '0;
            mem_rd      <= 1'b1;
            mem_addr    <= ADDR_W'(CFG_BASE + CFG_N_OFS);
          end else if (start && state != S_IDLE) begin
            state  <= S_ERR_INIT;
            mode_q <= norm_mode;
            grow_q <= grow_en;
            idx    <= '0;
            if (state == S_ERROR) retry_count <= '0;
          end
        end
        S_CFG_N: begin
          state    <= S_CFG_T;
          mem_rd   <= 1'b1;
          mem_addr <= ADDR_W'(CFG_BASE + CFG_T_OFS);
        end
        S_CFG_T: begin
          state    <= S_CFG_H;
          n        <= mem_data[N_W-1:0];
          mem_rd   <= 1'b1;
          mem_addr <= ADDR_W'(CFG_BASE + CFG_H_OFS);
        end
        S_CFG_H: begin
          state <= S_CFG_LAST;
          tol   <= mem_data;
        end
        S_CFG_LAST: begin
          state <= S_DONE_INIT;
          step  <= clamp_h(mem_data);
        end
        S_ERR_INIT: begin
          state    <= S_ERR_RD_Y;
          mem_rd   <= 1'b1;
          mem_addr <= ADDR_W'(Y_BASE) + ADDR_W'(idx);
        end
        S_ERR_RD_Y: begin
          state    <= S_ERR_RD_Z;
          mem_rd   <= 1'b1;
          mem_addr <= ADDR_W'(Z_BASE) + ADDR_W'(idx);
        end
        S_ERR_RD_Z: begin
          state <= S_ERR_ACC;
          y_q   <= mem_data;
        end
        S_ERR_ACC: begin
          if (acc_sat) begin
            state <= S_ERROR;
          end else if (idx == n_last) begin
            state <= S_CMP;
          end else begin
            state    <= S_ERR_RD_Y;
            idx      <= idx_nxt;
            mem_rd   <= 1'b1;
            mem_addr <= ADDR_W'(Y_BASE) + ADDR_W'(idx_nxt);
          end
        end
        S_CMP: begin
          err_norm <= acc;
          if ($signed(acc) <= $signed(tol)) begin
            retry_count <= '0;
            if (grow_q && ($signed(acc) < ($signed(tol) >>> GROW_SHIFT))) step <= h_grown;
            state <= S_DONE_PROCEED;
          end else begin
            retry_count <= retry_count + 1'b1;
            if (retry_count == ($clog2(MAX_RETRY+1))'(MAX_RETRY - 1)) begin
              state <= S_ERROR;
            end else begin
              state     <= S_MUL;
              mul_start <= 1'b1;
            end
          end
        end
        S_MUL: state <= S_WAIT_MUL;
        S_WAIT_MUL: begin
          // overflow wins over a coincident done
          if (mul_overflow) begin
            state <= S_ERROR;
          end else if (mul_done) begin
            state     <= S_DIV;
            product   <= mul_result;
            div_start <= 1'b1;
          end
        end
        S_DIV: state <= S_WAIT_DIV;
        S_WAIT_DIV: begin
          if (div_overflow) begin
            state <= S_ERROR;
          end else if (div_done) begin
            state <= S_CLAMP;
            quot  <= div_quot;
          end
        end
        S_CLAMP: begin
          state <= S_DONE_NO_PROCEED;
          step  <= clamp_h(quot);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_control_engine.sv
// Directed bench for step_control_engine with a spec-level reference model,
// memory / multiplier / divider responders and a per-cycle output comparator.
module tb_step_control_engine;

  localparam int     MUL_LAT = 4;
  localparam int     DIV_LAT = 3;
  localparam longint LIM     = 64'sd2147483648;
  localparam longint HMAX_M  = 64'sd1073741824;

  logic        clk = 1'b0;
  logic        rst;
  logic        init, start, norm_mode, grow_en;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        mul_start, mul_done, mul_overflow;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        div_start, div_done, div_overflow;
  logic [31:0] div_num, div_den, div_quot;
  logic [31:0] step, err_norm;
  logic        done, proceed, error_failure;
  logic [2:0]  retry_count;

  logic [31:0] mem [0:1023];
  logic [15:0] rd_log [$];
  logic [15:0] mem_a;
  longint      mp, dn, dd, dq;
  bit          force_mul_ovf = 1'b0;
  bit          chk_en = 1'b0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          cyc;

  // reference model state
  int          m_n;
  longint      m_tol, m_h, m_err;
  int          m_retry;
  bit          m_done, m_proceed, m_error;

  always #5 clk = ~clk;

  step_control_engine dut (
    .clk           (clk),
    .rst           (rst),
    .init          (init),
    .start         (start),
    .norm_mode     (norm_mode),
    .grow_en       (grow_en),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mul_start     (mul_start),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_done      (mul_done),
    .mul_result    (mul_result),
    .mul_overflow  (mul_overflow),
    .div_start     (div_start),
    .div_num       (div_num),
    .div_den       (div_den),
    .div_done      (div_done),
    .div_quot      (div_quot),
    .div_overflow  (div_overflow),
    .step          (step),
    .err_norm      (err_norm),
    .done          (done),
    .proceed       (proceed),
    .error_failure (error_failure),
    .retry_count   (retry_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // memory: data for a read strobed in cycle k is valid through cycle k+1
  initial begin
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        mem_a = mem_addr;
        @(posedge clk);
        #1 mem_data = mem[mem_a[9:0]];
      end
    end
  end

  always @(negedge clk) if (mem_rd) rd_log.push_back(mem_addr);

  initial begin
    mul_done = 1'b0; mul_result = '0; mul_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        mp = longint'($signed(mul_a)) * longint'($signed(mul_b));
        repeat (MUL_LAT - 1) @(negedge clk);
        mul_done     = 1'b1;
        mul_result   = mp[31:0];
        mul_overflow = force_mul_ovf || (mp >= LIM) || (mp < -LIM);
        @(negedge clk);
        mul_done = 1'b0; mul_overflow = 1'b0;
      end
    end
  end

  initial begin
    div_done = 1'b0; div_quot = '0; div_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        dn = longint'($signed(div_num));
        dd = longint'($signed(div_den));
        dq = (dd == 0) ? 0 : dn / dd;
        repeat (DIV_LAT - 1) @(negedge clk);
        div_done     = 1'b1;
        div_quot     = dq[31:0];
        div_overflow = (dd == 0) || (dq >= LIM);
        @(negedge clk);
        div_done = 1'b0; div_overflow = 1'b0;
      end
    end
  end

  // compare process: resting outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("step",          step,          m_h);
      check("err_norm",      err_norm,      m_err);
      check("retry_count",   retry_count,   m_retry);
      check("done",          done,          m_done);
      check("proceed",       proceed,       m_proceed);
      check("error_failure", error_failure, m_error);
    end
  end

  function automatic longint clamp_m(input longint v);
    if (v < 1) return 1;
    if (v > HMAX_M) return HMAX_M;
    return v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_tol = 0; m_h = 0; m_err = 0; m_retry = 0;
    m_done = 0; m_proceed = 0; m_error = 0;
  endtask

  task automatic model_init();
    m_n     = int'(mem[0][7:0]);
    m_tol   = longint'($signed(mem[1]));
    m_h     = clamp_m(longint'($signed(mem[2])));
    m_retry = 0;
    m_done = 1; m_proceed = 0; m_error = 0;
  endtask

  task automatic model_eval(input bit max_mode, input bit grow);
    longint acc, d, y, z, q;
    bit     bad;
    int     ne;
    if (m_error) m_retry = 0;
    ne  = (m_n == 0) ? 1 : m_n;
    acc = 0;
    bad = 0;
    for (int i = 0; i < ne; i++) begin
      y = longint'($signed(mem[16 + i]));
      z = longint'($signed(mem[512 + i]));
      d = (y > z) ? y - z : z - y;
      if (d >= LIM) bad = 1;
      acc = max_mode ? ((d > acc) ? d : acc) : acc + d;
      if (acc >= LIM) bad = 1;
    end
    m_proceed = 0;
    if (bad) begin
      m_done = 0; m_error = 1;
      return;
    end
    m_err = acc;
    if (acc <= m_tol) begin
      m_retry = 0;
      if (grow && acc < (m_tol >>> 3)) m_h = (2 * m_h > HMAX_M) ? HMAX_M : 2 * m_h;
      m_done = 1; m_proceed = 1; m_error = 0;
    end else begin
      m_retry++;
      if (m_retry == 4 || force_mul_ovf || (m_h * m_tol >= LIM)) begin
        m_done = 0; m_error = 1;
      end else begin
        q = (m_h * m_tol) / acc;
        m_h = clamp_m(q);
        m_done = 1; m_error = 0;
      end
    end
  endtask

  task automatic wait_rest(output int c);
    c = 1;
    while (!(done || error_failure) && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    check("op_completes", done || error_failure, 1);
  endtask

  task automatic settle();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
  endtask

  task automatic pulse_start(input bit max_mode, input bit grow);
    @(negedge clk);
    norm_mode = max_mode; grow_en = grow; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_init(input bit with_start, output int c);
    @(negedge clk);
    init = 1'b1; start = with_start;
    rd_log.delete();
    @(posedge clk);
    #1 init = 1'b0; start = 1'b0;
    wait_rest(c);
    model_init();
  endtask

  task automatic run_eval(input bit max_mode, input bit grow, output int c);
    pulse_start(max_mode, grow);
    wait_rest(c);
    model_eval(max_mode, grow);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    init = 0; start = 0; norm_mode = 0; grow_en = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    settle();
    @(negedge clk) rst = 1'b1;

    mem[0] = 3; mem[1] = 100; mem[2] = 50;
    mem[16] = 10; mem[17] = 20; mem[18] = 30;
    mem[512] = 12; mem[513] = 18; mem[514] = 29;

    do_init(1'b0, cyc);
    check("init_latency", cyc, 5);
    check("init_read_count", rd_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check("init_read_addr", (rd_log.size() > i) ? longint'(rd_log[i]) : -1, i);
    check("init_step", step, 50);
    settle();

    run_eval(1'b0, 1'b0, cyc);
    check("eval_latency_n3", cyc, 12);
    check("sum_norm", err_norm, 5);
    check("sum_proceed", proceed, 1);
    check("sum_retry", retry_count, 0);
    settle();

    run_eval(1'b1, 1'b0, cyc);
    check("max_norm", err_norm, 2);
    settle();

    run_eval(1'b0, 1'b1, cyc);
    check("grow_step", step, 100);
    settle();

    // reject chain: max-mode norm becomes 200 against tol 100
    mem[512] = 210;
    do_init(1'b0, cyc);
    settle();
    run_eval(1'b1, 1'b0, cyc);
    check("reject_step", step, 25);
    check("reject_done", done, 1);
    check("reject_proceed", proceed, 0);
    check("reject_retry", retry_count, 1);
    settle();
    for (int k = 0; k < 3; k++) begin
      run_eval(1'b1, 1'b0, cyc);
      settle();
    end
    check("retry_cap_error", error_failure, 1);
    check("retry_cap_count", retry_count, 4);
    check("retry_cap_step", step, 6);

    pulse_start(1'b1, 1'b0);
    check("retry_cleared", retry_count, 0);
    wait_rest(cyc);
    model_eval(1'b1, 1'b0);
    check("rerun_step", step, 3);
    settle();

    // overflow arrives together with done
    force_mul_ovf = 1'b1;
    run_eval(1'b1, 1'b0, cyc);
    force_mul_ovf = 1'b0;
    check("mulovf_error", error_failure, 1);
    check("mulovf_step", step, 3);
    settle();

    // n = 0 acts as one component; h = 0 clamps to H_MIN
    mem[0] = 0; mem[2] = 0; mem[512] = 12;
    do_init(1'b0, cyc);
    check("hmin_step", step, 1);
    settle();
    run_eval(1'b0, 1'b0, cyc);
    check("n0_latency", cyc, 6);
    check("n0_norm", err_norm, 2);
    settle();

    // growth saturates at H_MAX
    mem[0] = 3; mem[2] = 32'h3000_0000;
    do_init(1'b0, cyc);
    settle();
    run_eval(1'b0, 1'b1, cyc);
    check("hmax_step", step, 64'd1073741824);
    settle();

    // init wins over a simultaneous start; |y-z| = 2^31 faults
    mem[0] = 1; mem[16] = 32'h7FFF_FFFF; mem[512] = 32'hFFFF_FFFF;
    do_init(1'b1, cyc);
    check("init_over_start_latency", cyc, 5);
    settle();
    run_eval(1'b0, 1'b0, cyc);
    check("bigdiff_error", error_failure, 1);
    settle();

    // async reset in the middle of the error loop
    mem[0] = 3; mem[2] = 50; mem[16] = 10; mem[512] = 12;
    do_init(1'b0, cyc);
    settle();
    pulse_start(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_mem_rd", mem_rd, 1);
    #2 rst = 1'b0;
    #1;
    check("async_step", step, 0);
    check("async_err_norm", err_norm, 0);
    check("async_mem_rd", mem_rd, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_done", done, 0);
    model_reset();
    settle();
    @(negedge clk) rst = 1'b1;
    do_init(1'b0, cyc);
    settle();
    run_eval(1'b0, 1'b0, cyc);
    check("recover_norm", err_norm, 5);
    settle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
